// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and the {pc, data} fetch entry type for the 16-bit CPU.
package cpu_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 16;
   localparam int RESET_PC = 10;
   localparam int PC_STEP  = 1;
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-unit bus; instruction-memory read port, redirect input, decode handshake.
// master (fetch unit): drives imem_req/imem_addr and inst_valid/inst_data/inst_pc.
// slave (memory + decode side): drives imem_rdata, redirect_valid/redirect_pc, inst_ready.
interface fetch_unit_if #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;
   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_rdata, redirect_valid, redirect_pc, inst_ready
   );
   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_rdata, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry synchronous FIFO with head peek and occupancy count.
// Ports: clk/rst (sync active-high, also used as flush), i_push/i_data write,
// i_pop read, o_head current head entry, o_count occupancy 0..DEPTH.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd, r_wr;
   logic [AW:0]      r_count;
   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (i_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: resettable PC, redirect and prefetch buffer feeding decode over valid/ready.
// Ports: clk, rst (sync active-high), bus (fetch_unit_if.master): 1-cycle-latency
// instruction memory read port, redirect_valid/redirect_pc, inst_* delivery handshake.
module fetch_unit #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int RESET_PC = cpu_pkg::RESET_PC,
   parameter int PC_STEP  = cpu_pkg::PC_STEP,
   parameter int DEPTH    = 4
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } entry_t;
   logic [ADDR_W-1:0] r_fetch_pc, r_inflight_pc;
   logic              r_inflight, r_kill;
   logic              w_req, w_push, w_pop, w_valid, w_clr;
   logic [CW-1:0]     w_count;
   entry_t            w_head, w_tail;
   // credit: buffered plus in-flight words may never exceed the buffer, so a push always fits
   assign w_req   = !rst && !bus.redirect_valid && ((w_count + CW'(r_inflight)) < CW'(DEPTH));
   // the response landing in a redirect cycle belongs to the old stream and is flushed with it
   assign w_push  = r_inflight && !r_kill && !bus.redirect_valid;
   assign w_valid = !rst && (w_count != '0);
   assign w_pop   = w_valid && bus.inst_ready;
   assign w_clr   = rst || bus.redirect_valid;
   assign w_tail  = '{pc: r_inflight_pc, data: bus.imem_rdata};
   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = rst ? ADDR_W'(RESET_PC) : r_fetch_pc;
   assign bus.inst_valid = w_valid;
   assign bus.inst_data  = w_valid ? w_head.data : '0;
   assign bus.inst_pc    = w_valid ? w_head.pc : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= ADDR_W'(RESET_PC);
         r_inflight_pc <= ADDR_W'(RESET_PC);
         r_inflight    <= 1'b0;
         r_kill        <= 1'b0;
      end else begin
         r_inflight <= w_req;
         r_kill     <= bus.redirect_valid && r_inflight;
         if (bus.redirect_valid) r_fetch_pc <= bus.redirect_pc;
         else if (w_req) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + ADDR_W'(PC_STEP);
         end
      end
   end
   sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (w_clr),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_tail),
      .o_head  (w_head),
      .o_count (w_count)
   );
endmodule
